// File: rtl/conv_pkg.sv
// Shared convolution types and constants used by the window generator and the
// convolution_point wrappers.
package conv_pkg;

    localparam int unsigned KSIZE        = 5;
    localparam int unsigned BITWIDTH     = 16;
    localparam int unsigned LENET_DIM_L1 = 28;
    localparam int unsigned LENET_DIM_L2 = 14;
    localparam int unsigned LENET_DIM_L3 = 10;

    typedef logic signed [BITWIDTH-1:0]    pixel_t;
    typedef pixel_t [KSIZE-1:0][KSIZE-1:0] window_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One-row delay memory: combinational read of the old word, synchronous write
// of the new one at the same address (read-before-write).
module conv_line_buffer #(
    parameter int unsigned bitwidth  = 16,
    parameter int unsigned img_width = 28,
    localparam int unsigned AW       = $clog2(img_width)
) (
    input  logic                clk,
    input  logic [AW-1:0]       addr,
    input  logic                we,
    input  logic [bitwidth-1:0] wr_data,
    output logic [bitwidth-1:0] rd_data
);

    logic [bitwidth-1:0] mem [img_width];

    // Contents are never reset; every word is rewritten before it is consumed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 5x5 window generator: raster pixels in, every fully-populated
// valid-convolution window out with its top-left coordinate.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned bitwidth   = BITWIDTH,
    parameter int unsigned img_width  = LENET_DIM_L1,
    parameter int unsigned img_height = LENET_DIM_L1
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic signed [bitwidth-1:0]                        in_pixel,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    output logic signed [KSIZE-1:0][KSIZE-1:0][bitwidth-1:0]  map_block,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [$clog2(img_height)-1:0]                     out_row,
    output logic [$clog2(img_width)-1:0]                      out_col,
    output logic                                              out_last
);

    localparam int unsigned RW    = $clog2(img_height);
    localparam int unsigned CW    = $clog2(img_width);
    localparam int unsigned NLINE = KSIZE - 1;

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          accept;
    logic          complete;
    logic          col_end;
    logic          row_end;

    logic [NLINE-1:0][bitwidth-1:0]               lb_rd;
    logic [NLINE-1:0][bitwidth-1:0]               lb_wr;
    logic [KSIZE-1:0][bitwidth-1:0]               col_in;
    logic signed [KSIZE-1:0][KSIZE-1:0][bitwidth-1:0] win;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_end  = (col == CW'(img_width - 1));
    assign row_end  = (row == RW'(img_height - 1));
    assign complete = (row >= RW'(KSIZE - 1)) && (col >= CW'(KSIZE - 1));

    // Rows ripple down the chain; column vector is oldest row first.
    always_comb begin
        lb_wr  = '0;
        col_in = '0;
        for (int k = 0; k < NLINE - 1; k++) begin
            lb_wr[k] = lb_rd[k+1];
        end
        lb_wr[NLINE-1] = in_pixel;
        for (int k = 0; k < NLINE; k++) begin
            col_in[k] = lb_rd[k];
        end
        col_in[KSIZE-1] = in_pixel;
    end

    for (genvar k = 0; k < NLINE; k++) begin : g_lb
        conv_line_buffer #(
            .bitwidth (bitwidth),
            .img_width(img_width)
        ) u_lb (
            .clk    (clk),
            .addr   (col),
            .we     (accept),
            .wr_data(lb_wr[k]),
            .rd_data(lb_rd[k])
        );
    end

    // Position of the next pixel; wraps at end of frame with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Window shifts left one column per accepted pixel; stale columns from the
    // previous row are flushed before col reaches 4.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win <= '0;
        end else if (accept) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE - 1; j++) begin
                    win[i][j] <= win[i][j+1];
                end
                win[i][KSIZE-1] <= col_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
        end else if (accept && complete) begin
            out_valid <= 1'b1;
            out_row   <= row - RW'(KSIZE - 1);
            out_col   <= col - CW'(KSIZE - 1);
            out_last  <= row_end && col_end;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign map_block = win;

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized scoreboard bench for conv_window_gen at 28x28 with a frame-array
// reference model.
module tb_conv_window_gen;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int NW = (H - 4) * (W - 4);

    typedef struct packed {
        logic [4:0]        row;
        logic [4:0]        col;
        logic              last;
        logic [24:0][15:0] win;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic signed [15:0]      in_pixel;
    logic                    in_valid;
    logic                    in_ready;
    logic [4:0][4:0][15:0]   map_block;
    logic                    out_valid;
    logic                    out_ready;
    logic [4:0]              out_row;
    logic [4:0]              out_col;
    logic                    out_last;

    exp_t        sb[$];
    logic [15:0] img [H][W];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_win    = 0;
    int          rdy_pct  = 100;
    bit          bp_arm   = 1'b0;

    conv_window_gen #(.bitwidth(16), .img_width(W), .img_height(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_pixel (in_pixel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .map_block(map_block),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row  (out_row),
        .out_col  (out_col),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input bit ok, input logic [511:0] act,
                       input logic [511:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        n_win++;
        if (sb.size() == 0) begin
            chk("unexpected_window", 1'b0, 512'({out_row, out_col}), 512'(0));
        end else begin
            e = sb.pop_front();
            chk($sformatf("window_pos r%0d c%0d", e.row, e.col),
                out_row == e.row && out_col == e.col && out_last == e.last,
                512'({out_row, out_col, out_last}), 512'({e.row, e.col, e.last}));
            chk($sformatf("window_data r%0d c%0d", e.row, e.col),
                map_block == e.win, 512'(map_block), 512'(e.win));
        end
    endtask

    // Consumer: random out_ready, optional 10-cycle stall on the (0,0) window.
    initial begin
        logic [399:0] held;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_arm && out_valid && out_row == 5'd0 && out_col == 5'd0) begin
                bp_arm    = 1'b0;
                out_ready = 1'b0;
                held      = map_block;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("bp_hold", !in_ready && out_valid && map_block == held &&
                        out_row == 5'd0 && out_col == 5'd0 && !out_last,
                        512'({in_ready, out_valid, map_block}), 512'({1'b0, 1'b1, held}));
                    if (k != 9) begin
                        @(posedge clk); #1;
                    end
                end
                out_ready = 1'b1;
            end else begin
                out_ready = ($urandom_range(99) < rdy_pct);
                @(negedge clk);
            end
            if (out_valid && out_ready) pop_check();
        end
    end

    // Producer: drives frames, records the image, pushes expected windows.
    task automatic run_frames(input int nfr, input int base0, input bit rnd,
                              input int in_pct, input bit do_abort);
        bit fire;
        int tries;
        bit stop = 1'b0;
        for (int f = 0; f < nfr && !stop; f++) begin
            for (int r = 0; r < H && !stop; r++) begin
                for (int c = 0; c < W && !stop; c++) begin
                    logic [15:0] p;
                    p = rnd ? 16'($urandom) : 16'(base0 + f * 1000 + r * W + c);
                    if (do_abort && r == 10 && c == 7) begin
                        #2 rst_n = 1'b0;
                        #1;
                        chk("async_reset_outputs", !out_valid && !out_last && out_row == 5'd0 &&
                            out_col == 5'd0 && map_block == '0 && in_ready,
                            512'({out_valid, out_last, out_row, out_col, in_ready, map_block}),
                            512'({1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 400'd0}));
                        sb.delete();
                        in_valid = 1'b0;
                        @(negedge clk);
                        rst_n = 1'b1;
                        @(posedge clk); #1;
                        stop = 1'b1;
                    end else begin
                        img[r][c] = p;
                        fire  = 1'b0;
                        tries = 0;
                        while (!fire && tries < 2000) begin
                            in_valid = ($urandom_range(99) < in_pct);
                            in_pixel = p;
                            @(negedge clk); #1;
                            fire = in_valid && in_ready;
                            if (fire && r >= 4 && c >= 4) begin
                                exp_t e;
                                e.row  = 5'(r - 4);
                                e.col  = 5'(c - 4);
                                e.last = (r == H - 1) && (c == W - 1);
                                for (int i = 0; i < 5; i++)
                                    for (int j = 0; j < 5; j++)
                                        e.win[i*5+j] = img[r-4+i][c-4+j];
                                sb.push_back(e);
                            end
                            @(posedge clk); #1;
                            tries++;
                        end
                        if (!fire) begin
                            chk("accept_timeout", 1'b0, 512'(0), 512'(1));
                            stop = 1'b1;
                        end else if (r >= 4 && c >= 4) begin
                            chk("latency", out_valid && out_row == 5'(r - 4) && out_col == 5'(c - 4),
                                512'({out_valid, out_row, out_col}),
                                512'({1'b1, 5'(r - 4), 5'(c - 4)}));
                        end
                    end
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int nexp);
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 2000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk({name, "_drain"}, sb.size() == 0 && !out_valid,
            512'({sb.size(), out_valid}), 512'(0));
        chk({name, "_count"}, n_win == nexp, 512'(n_win), 512'(nexp));
    endtask

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", !out_valid && !out_last && out_row == 5'd0 && out_col == 5'd0 &&
            map_block == '0 && in_ready,
            512'({out_valid, out_last, out_row, out_col, in_ready, map_block}),
            512'({1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 400'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        n_win = 0;
        run_frames(1, 0, 1'b0, 100, 1'b0);
        drain("single_frame", NW);

        n_win  = 0;
        bp_arm = 1'b1;
        run_frames(1, 0, 1'b0, 100, 1'b0);
        drain("backpressure", NW);
        chk("bp_triggered", !bp_arm, 512'(bp_arm), 512'(0));

        n_win   = 0;
        rdy_pct = 50;
        run_frames(1, 0, 1'b0, 50, 1'b0);
        run_frames(1, 0, 1'b1, 50, 1'b0);
        drain("random_throttle", 2 * NW);

        n_win   = 0;
        rdy_pct = 100;
        run_frames(2, 0, 1'b0, 100, 1'b0);
        drain("back_to_back", 2 * NW);

        run_frames(1, 0, 1'b0, 100, 1'b1);
        n_win = 0;
        run_frames(1, 0, 1'b1, 100, 1'b0);
        drain("after_reset", NW);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
